rs232_receiver: RTL and testbench

RS232_RECEIVER -- requirements
Module: rs232_receiver

---
 rtl/rs232_receiver_if.sv | 22 ++
 rtl/rs232_receiver.sv | 121 ++++++++++++
 tb/tb_rs232_receiver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rs232_receiver_if.sv
// Receiver-side signal bundle: serial line and consumer handshake in,
// received byte, status pulses and debug state out.
interface rs232_receiver_if;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic [2:0] state;

  modport master (
    output rxd, rx_ready,
    input  rx_data, rx_valid, frame_error, overrun, busy, state
  );

  modport slave (
    input  rxd, rx_ready,
    output rx_data, rx_valid, frame_error, overrun, busy, state
  );
endinterface

// File: rtl/rs232_receiver.sv
// 8N1 serial receiver: mid-bit sampling from a start-edge-aligned counter,
// single-entry output register with valid/ready and overrun/frame-error pulses.
module rs232_receiver #(
  parameter int CLK_DIV = 434
) (
  input  logic           clk,
  input  logic           reset_n,
  rs232_receiver_if.slave rx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          sync_q, rxd_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          sample, deliver, bad_stop, busy;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxd_s_q) state_d = START;
      START:   if (sample) state_d = rxd_s_q ? IDLE : DATA;
      DATA:    if (sample && bit_q == 3'd7) state_d = STOP;
      STOP:    if (sample) state_d = rxd_s_q ? IDLE : BREAK;
      BREAK:   if (rxd_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    sample   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      START:     sample = (cnt_q == HALF_M1);
      DATA, STOP: sample = (cnt_q == FULL_M1);
      default:   sample = 1'b0;
    endcase
    deliver  = (state_q == STOP) && sample &&  rxd_s_q;
    bad_stop = (state_q == STOP) && sample && !rxd_s_q;
  end

  // Datapath next-state; counter only runs while timing a bit
  always_comb begin
    cnt_d      = '0;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (state_d == state_q && !sample &&
        (state_q == START || state_q == DATA || state_q == STOP))
      cnt_d = cnt_q + CW'(1);
    if (state_q == START && sample) bit_d = 3'd0;
    if (state_q == DATA && sample) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {rxd_s_q, shift_q[7:1]};
    end
    if (rx_valid_q && rx.rx_ready) rx_valid_d = 1'b0;
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end
    fe_d  = bad_stop;
    ovr_d = deliver && rx_valid_q && !rx.rx_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q     <= 1'b1;
      rxd_s_q    <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= rx.rxd;
      rxd_s_q    <= sync_q;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx.rx_data     = rx_data_q;
  assign rx.rx_valid    = rx_valid_q;
  assign rx.frame_error = fe_q;
  assign rx.overrun     = ovr_q;
  assign rx.busy        = busy;
  assign rx.state       = state_q;

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver at CLK_DIV=8 with hand-computed expectations.
module tb_rs232_receiver;

  logic clk = 1'b0;
  logic reset_n;
  rs232_receiver_if rxif();

  rs232_receiver #(.CLK_DIV(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rxif.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int start_cyc = 0, idle_cyc = 0, rise_cyc = 0;
  int vld_cycles = 0, fe_cnt = 0, ovr_cnt = 0, acc_cnt = 0, brk_exit = 0;
  logic [7:0] last_acc = 8'h00, rise_data = 8'h00;
  logic [2:0] prev_st = 3'd0;
  logic       prev_vld = 1'b0;

  always @(posedge clk) cyc++;

  // Event log sampled mid-cycle
  always @(negedge clk) begin
    if (rxif.state == 3'd1 && prev_st == 3'd0) start_cyc = cyc;
    if (rxif.state == 3'd0 && prev_st == 3'd1) idle_cyc = cyc;
    if (rxif.state == 3'd0 && prev_st == 3'd4) brk_exit++;
    if (rxif.rx_valid && !prev_vld) begin rise_cyc = cyc; rise_data = rxif.rx_data; end
    if (rxif.rx_valid) vld_cycles++;
    if (rxif.frame_error) fe_cnt++;
    if (rxif.overrun) ovr_cnt++;
    if (rxif.rx_valid && rxif.rx_ready) begin acc_cnt++; last_acc = rxif.rx_data; end
    prev_st  = rxif.state;
    prev_vld = rxif.rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first, stop; 8 cycles per bit
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxif.rxd = f[i];
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_vld, b_fe, b_ovr, b_acc, b_brk;

  initial begin
    reset_n       = 1'b0;
    rxif.rxd      = 1'b1;
    rxif.rx_ready = 1'b0;
    idle(3);
    chk("rst_state", rxif.state, 3'd0);
    chk("rst_valid", rxif.rx_valid, 1'b0);
    chk("rst_data", rxif.rx_data, 8'h00);
    chk("rst_busy", rxif.busy, 1'b0);
    chk("rst_fe", rxif.frame_error, 1'b0);
    chk("rst_ovr", rxif.overrun, 1'b0);
    reset_n = 1'b1;
    idle(4);

    // Single byte, consumer always ready
    rxif.rx_ready = 1'b1;
    b_vld = vld_cycles; b_fe = fe_cnt; b_ovr = ovr_cnt; b_acc = acc_cnt;
    send_frame(8'hA5, 1'b1);
    idle(10);
    chk("a5_data", rise_data, 8'hA5);
    chk("a5_vld_len", vld_cycles - b_vld, 1);
    chk("a5_latency", rise_cyc - start_cyc, 76);
    chk("a5_fe", fe_cnt - b_fe, 0);
    chk("a5_ovr", ovr_cnt - b_ovr, 0);
    chk("a5_idle", rxif.state, 3'd0);

    // Short glitch on idle line
    b_vld = vld_cycles; b_fe = fe_cnt;
    rxif.rxd = 1'b0;
    idle(3);
    rxif.rxd = 1'b1;
    idle(12);
    chk("glitch_abort", idle_cyc - start_cyc, 4);
    chk("glitch_vld", vld_cycles - b_vld, 0);
    chk("glitch_fe", fe_cnt - b_fe, 0);
    chk("glitch_state", rxif.state, 3'd0);

    // Bad stop bit then held break
    b_vld = vld_cycles; b_fe = fe_cnt; b_brk = brk_exit;
    send_frame(8'h3C, 1'b0);
    idle(40);
    chk("brk_state", rxif.state, 3'd4);
    chk("brk_busy", rxif.busy, 1'b1);
    chk("brk_fe", fe_cnt - b_fe, 1);
    rxif.rxd = 1'b1;
    idle(4);
    chk("brk_exit", brk_exit - b_brk, 1);
    chk("brk_idle", rxif.state, 3'd0);
    chk("brk_vld", vld_cycles - b_vld, 0);
    idle(10);

    // Back-to-back with stalled consumer -> overrun
    rxif.rx_ready = 1'b0;
    b_ovr = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    chk("ovr_data", rxif.rx_data, 8'h22);
    chk("ovr_valid", rxif.rx_valid, 1'b1);
    chk("ovr_pulse", ovr_cnt - b_ovr, 1);
    rxif.rx_ready = 1'b1;
    idle(1);
    rxif.rx_ready = 1'b0;
    idle(1);
    chk("ovr_drain", rxif.rx_valid, 1'b0);
    chk("ovr_acc", last_acc, 8'h22);
    idle(10);

    // Accept old byte in the exact cycle the new one lands
    b_ovr = ovr_cnt; b_acc = acc_cnt;
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1 rxif.rx_ready = 1'b1;
        @(posedge clk);
        #1 rxif.rx_ready = 1'b0;
      end
    join
    idle(3);
    chk("same_data", rxif.rx_data, 8'h22);
    chk("same_valid", rxif.rx_valid, 1'b1);
    chk("same_ovr", ovr_cnt - b_ovr, 0);
    chk("same_acc_cnt", acc_cnt - b_acc, 1);
    chk("same_acc", last_acc, 8'h11);
    rxif.rx_ready = 1'b1;
    idle(2);
    chk("same_drain", rxif.rx_valid, 1'b0);
    idle(10);

    // Reset in the middle of data bit 4
    b_fe = fe_cnt; b_ovr = ovr_cnt; b_acc = acc_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (43) @(posedge clk);
        #1;
        chk("mid_data", rxif.state, 3'd2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_state", rxif.state, 3'd0);
        chk("mid_rst_busy", rxif.busy, 1'b0);
        chk("mid_rst_data", rxif.rx_data, 8'h00);
        reset_n = 1'b1;
      end
    join
    idle(6);
    chk("post_rst_acc", acc_cnt - b_acc, 0);
    send_frame(8'h5A, 1'b1);
    idle(6);
    chk("post_rst_cnt", acc_cnt - b_acc, 1);
    chk("post_rst_byte", last_acc, 8'h5A);
    chk("post_rst_fe", fe_cnt - b_fe, 0);
    chk("post_rst_ovr", ovr_cnt - b_ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
